// File: rtl/automorph_pkg.sv
// automorph_pkg: shared definitions for the Galois-automorphism sequencer.
//   state_e       - sequencer FSM states (2-bit encoding)
//   N_COEFF       - coefficients per limb for the default index width
//   DRAIN_CYCLES  - DRAIN state length for the default read latency
//   n_coeff()     - coefficients per limb for an arbitrary index width
//   drain_cycles()- DRAIN state length for an arbitrary read latency
package automorph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int DEF_INDEX_WIDTH = 13;
  localparam int DEF_RD_LAT      = 2;

  localparam int N_COEFF      = 1 << (DEF_INDEX_WIDTH - 1);
  localparam int DRAIN_CYCLES = DEF_RD_LAT + 1;

  function automatic int n_coeff(input int index_width);
    return 1 << (index_width - 1);
  endfunction

  // One extra cycle beyond the read latency covers the shuffle write stage.
  function automatic int drain_cycles(input int rd_lat);
    return rd_lat + 1;
  endfunction

endpackage

// File: rtl/automorph_ctrl_valid_delay_line.sv
// valid_delay_line: fixed-depth shift register, asynchronously cleared to 0.
//   clk    in          clock
//   rst_n  in          asynchronous active-low reset
//   din_i  in  WIDTH   value entering the line
//   dout_o out WIDTH   din_i delayed by DEPTH cycles (DEPTH >= 1)
module valid_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/automorph_ctrl.sv
// automorph_ctrl: job sequencer for the Galois-automorphism shuffle datapath.
// Streams every limb's N coefficients out of source BRAM in natural order,
// feeds the shuffle unit a read-latency-aligned valid, tags shuffle writes
// with their limb, and separates limbs with an idle bubble so the shuffle
// unit can clear its index accumulator.
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset (aborts any job)
//   i_start       in   job request pulse, honoured only when idle
//   i_galois_elt  in   Galois element (must be odd)
//   i_num_limbs   in   limbs in job (must be nonzero)
//   o_busy        out  accepted start through done pulse inclusive
//   o_done        out  one-cycle job-complete pulse
//   o_err         out  one-cycle pulse on a rejected start
//   o_rd_en       out  source BRAM read enable
//   o_rd_addr     out  source coefficient address
//   o_rd_limb     out  limb being read
//   o_sh_valid    out  shuffle i_valid (o_rd_en delayed RD_LAT)
//   o_galois_elt  out  latched Galois element
//   o_wr_limb     out  limb of the shuffle write in flight
module automorph_ctrl
  import automorph_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int LIMB_WIDTH  = 4,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [INDEX_WIDTH-1:0] i_galois_elt,
  input  logic [LIMB_WIDTH-1:0]  i_num_limbs,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_rd_en,
  output logic [INDEX_WIDTH-2:0] o_rd_addr,
  output logic [LIMB_WIDTH-1:0]  o_rd_limb,
  output logic                   o_sh_valid,
  output logic [INDEX_WIDTH-1:0] o_galois_elt,
  output logic [LIMB_WIDTH-1:0]  o_wr_limb
);

  localparam int ADDR_W  = INDEX_WIDTH - 1;
  localparam int NC      = n_coeff(INDEX_WIDTH);
  localparam int DRAIN_N = drain_cycles(RD_LAT);
  localparam int CNT_MAX = (GAP_CYCLES > DRAIN_N) ? GAP_CYCLES : DRAIN_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NC - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_N - 1);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LIMB_WIDTH-1:0]  limb_q, limb_d;
  logic [LIMB_WIDTH-1:0]  nlimbs_q, nlimbs_d;
  logic [INDEX_WIDTH-1:0] galois_q, galois_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   rd_en;

  logic start_ok;
  logic start_good;
  logic accept;
  logic last_addr;
  logic last_limb;

  // busy_q is still high during the done cycle, so a start there is ignored.
  assign start_ok   = i_start && (state_q == ST_IDLE) && !busy_q;
  assign start_good = i_galois_elt[0] && (i_num_limbs != '0);
  assign accept     = start_ok && start_good;
  assign last_addr  = (addr_q == ADDR_LAST);
  assign last_limb  = (limb_q == (nlimbs_q - LIMB_WIDTH'(1)));

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      limb_q   <= '0;
      nlimbs_q <= '0;
      galois_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      limb_q   <= limb_d;
      nlimbs_q <= nlimbs_d;
      galois_q <= galois_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  if (last_addr) state_d = last_limb ? ST_DRAIN : ST_GAP;
      ST_GAP:   if (cnt_q == GAP_LAST) state_d = ST_READ;
      ST_DRAIN: if (cnt_q == DRAIN_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address, limb and bubble/drain counters
  always_comb begin
    addr_d   = addr_q;
    limb_d   = limb_q;
    nlimbs_d = nlimbs_q;
    galois_d = galois_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = '0;
          limb_d   = '0;
          nlimbs_d = i_num_limbs;
          galois_d = i_galois_elt;
          cnt_d    = '0;
        end
      end
      ST_READ: begin
        // Address wraps from N-1 to 0 by natural overflow.
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = '0;
        if (last_addr && !last_limb) limb_d = limb_q + LIMB_WIDTH'(1);
      end
      ST_GAP, ST_DRAIN: cnt_d = cnt_q + CNT_W'(1);
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    rd_en  = (state_q == ST_READ);
    done_d = (state_q == ST_DRAIN) && (cnt_q == DRAIN_LAST);
    err_d  = start_ok && !start_good;
    busy_d = busy_q;
    if (accept)      busy_d = 1'b1;
    else if (done_q) busy_d = 1'b0;
  end

  // Read enable becomes the shuffle valid after the BRAM latency.
  valid_delay_line #(
    .WIDTH (1),
    .DEPTH (RD_LAT)
  ) u_vld_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (rd_en),
    .dout_o (o_sh_valid)
  );

  // The shuffle writes one cycle after it sees valid, hence the extra stage.
  valid_delay_line #(
    .WIDTH (LIMB_WIDTH),
    .DEPTH (RD_LAT + 1)
  ) u_limb_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (limb_q),
    .dout_o (o_wr_limb)
  );

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_rd_en      = rd_en;
  assign o_rd_addr    = addr_q;
  assign o_rd_limb    = limb_q;
  assign o_galois_elt = galois_q;

endmodule

// File: tb/tb_automorph_ctrl.sv
// tb_automorph_ctrl: self-checking bench for automorph_ctrl.
// A small instance (N=8, RD_LAT=2, GAP=1) is compared every cycle against an
// arithmetic model of the job timeline; a default-size instance checks the
// full-length job timing.
module tb_automorph_ctrl;

  localparam int IW = 4;
  localparam int LW = 4;
  localparam int RL = 2;
  localparam int G  = 1;
  localparam int N  = 1 << (IW - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          s_start = 1'b0;
  logic [IW-1:0] s_gal = '0;
  logic [LW-1:0] s_limbs = '0;
  logic          s_busy, s_done, s_err, s_rd_en, s_sh_valid;
  logic [IW-2:0] s_rd_addr;
  logic [LW-1:0] s_rd_limb, s_wr_limb;
  logic [IW-1:0] s_gal_o;

  logic        b_start = 1'b0;
  logic [12:0] b_gal = '0;
  logic [3:0]  b_limbs = '0;
  logic        b_busy, b_done, b_err, b_rd_en, b_sh_valid;
  logic [11:0] b_rd_addr;
  logic [3:0]  b_rd_limb, b_wr_limb;
  logic [12:0] b_gal_o;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int cyc = 0;
  bit m_active = 0;
  int m_S = 0;
  int m_L = 0;
  int m_gal = 0;
  int m_err_cyc = -1;

  always #5 clk = ~clk;

  automorph_ctrl #(
    .INDEX_WIDTH (IW),
    .LIMB_WIDTH  (LW),
    .RD_LAT      (RL),
    .GAP_CYCLES  (G)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (s_start),
    .i_galois_elt (s_gal),
    .i_num_limbs  (s_limbs),
    .o_busy       (s_busy),
    .o_done       (s_done),
    .o_err        (s_err),
    .o_rd_en      (s_rd_en),
    .o_rd_addr    (s_rd_addr),
    .o_rd_limb    (s_rd_limb),
    .o_sh_valid   (s_sh_valid),
    .o_galois_elt (s_gal_o),
    .o_wr_limb    (s_wr_limb)
  );

  automorph_ctrl dut_big (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (b_start),
    .i_galois_elt (b_gal),
    .i_num_limbs  (b_limbs),
    .o_busy       (b_busy),
    .o_done       (b_done),
    .o_err        (b_err),
    .o_rd_en      (b_rd_en),
    .o_rd_addr    (b_rd_addr),
    .o_rd_limb    (b_rd_limb),
    .o_sh_valid   (b_sh_valid),
    .o_galois_elt (b_gal_o),
    .o_wr_limb    (b_wr_limb)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Is relative cycle r of an L-limb job a read cycle?
  function automatic bit rd_at(input int r, input int L);
    return (r >= 0) && (r < L * N + (L - 1) * G) && ((r % (N + G)) < N);
  endfunction

  // Per-cycle reference comparison of the small instance.
  initial begin : monitor
    int rel, dr, wr;
    bit e_busy, e_rd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active  = 0;
        m_gal     = 0;
        m_err_cyc = -1;
      end else begin
        rel    = m_active ? cyc - (m_S + 1) : -1000;
        dr     = m_L * N + (m_L - 1) * G - 1 + RL + 2;
        e_busy = m_active && (rel >= 0) && (rel <= dr);
        e_rd   = m_active && rd_at(rel, m_L);
        check("rd_en", 32'(s_rd_en), 32'(e_rd));
        if (e_rd) begin
          check("rd_addr", 32'(s_rd_addr), 32'(rel % (N + G)));
          check("rd_limb", 32'(s_rd_limb), 32'(rel / (N + G)));
        end
        check("sh_valid", 32'(s_sh_valid), 32'(m_active && rd_at(rel - RL, m_L)));
        wr = rel - RL - 1;
        if (m_active && rd_at(wr, m_L))
          check("wr_limb", 32'(s_wr_limb), 32'(wr / (N + G)));
        check("busy", 32'(s_busy), 32'(e_busy));
        check("done", 32'(s_done), 32'(m_active && rel == dr));
        check("err", 32'(s_err), 32'(cyc == m_err_cyc));
        check("galois", 32'(s_gal_o), 32'(m_gal));
        // Inputs seen now are the ones sampled on the coming rising edge.
        if (s_start && !e_busy) begin
          if (s_gal[0] && s_limbs != 0) begin
            m_active = 1;
            m_S      = cyc;
            m_L      = int'(s_limbs);
            m_gal    = int'(s_gal);
          end else begin
            m_err_cyc = cyc + 1;
          end
        end
      end
      cyc++;
    end
  end

  task automatic pulse_start(input logic [IW-1:0] g, input logic [LW-1:0] l);
    @(posedge clk); #1;
    s_start = 1'b1; s_gal = g; s_limbs = l;
    @(posedge clk); #1;
    s_start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (!s_busy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("idle_timeout", 32'(s_busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(s_busy), 0);
    check({tag, "_done"}, 32'(s_done), 0);
    check({tag, "_err"}, 32'(s_err), 0);
    check({tag, "_rd_en"}, 32'(s_rd_en), 0);
    check({tag, "_rd_addr"}, 32'(s_rd_addr), 0);
    check({tag, "_rd_limb"}, 32'(s_rd_limb), 0);
    check({tag, "_sh_valid"}, 32'(s_sh_valid), 0);
    check({tag, "_galois"}, 32'(s_gal_o), 0);
    check({tag, "_wr_limb"}, 32'(s_wr_limb), 0);
  endtask

  // Cycles from first o_rd_en through o_done, inclusive.
  task automatic time_job(input logic [IW-1:0] g, input logic [LW-1:0] l, input int exp_len);
    int n = 0;
    bit seen = 0;
    bit got = 0;
    pulse_start(g, l);
    for (int i = 0; i < 400; i++) begin
      if (s_rd_en) seen = 1;
      if (seen) n++;
      if (s_done) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("job_done_seen", 32'(got), 1);
    check("job_len", 32'(n), 32'(exp_len));
    @(posedge clk); #1;
    check("busy_after_done", 32'(s_busy), 0);
  endtask

  initial begin : driver
    bit hit;
    int n;
    bit seen, got;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    rst_n = 1'b1;

    // Single limb and three limbs with bubbles
    time_job(4'd3, 4'd1, 12);
    time_job(4'd5, 4'd3, 30);

    // Rejected starts
    pulse_start(4'd4, 4'd2);
    check("rej_even_busy", 32'(s_busy), 0);
    check("rej_even_err", 32'(s_err), 1);
    @(posedge clk); #1;
    check("rej_even_err_len", 32'(s_err), 0);
    pulse_start(4'd3, 4'd0);
    check("rej_zero_busy", 32'(s_busy), 0);
    check("rej_zero_err", 32'(s_err), 1);
    check("rej_zero_galois", 32'(s_gal_o), 5);
    @(posedge clk); #1;

    // Start while busy is ignored
    pulse_start(4'd3, 4'd2);
    repeat (3) @(posedge clk);
    #1 s_start = 1'b1; s_gal = 4'd7; s_limbs = 4'd1;
    @(posedge clk); #1 s_start = 1'b0;
    check("ignored_err", 32'(s_err), 0);
    wait_idle();
    check("ignored_galois", 32'(s_gal_o), 3);

    // Asynchronous reset mid-job at addr 5 of limb 1
    pulse_start(4'd3, 4'd2);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (s_rd_en && s_rd_addr == 3'd5 && s_rd_limb == 4'd1) begin hit = 1; break; end
    end
    check("reach_addr5_limb1", 32'(hit), 1);
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    time_job(4'd9, 4'd1, 12);

    // Randomized traffic, including starts while busy and illegal requests
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      s_start = ($urandom_range(0, 7) == 0);
      s_gal   = 4'($urandom_range(0, 15));
      s_limbs = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
    end
    @(posedge clk); #1 s_start = 1'b0;
    wait_idle();

    // Full-size job: 4096 coefficients, two limbs
    @(posedge clk); #1;
    b_start = 1'b1; b_gal = 13'd3; b_limbs = 4'd2;
    @(posedge clk); #1 b_start = 1'b0;
    n = 0; seen = 0; got = 0;
    for (int i = 0; i < 9000; i++) begin
      if (b_rd_en && !seen) begin
        seen = 1;
        check("big_first_addr", 32'(b_rd_addr), 0);
      end
      if (seen) n++;
      if (b_done) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("big_done_seen", 32'(got), 1);
    check("big_len", 32'(n), 8197);
    check("big_galois", 32'(b_gal_o), 3);
    check("big_rd_limb", 32'(b_rd_limb), 1);
    check("big_wr_limb", 32'(b_wr_limb), 1);
    check("big_busy_at_done", 32'(b_busy), 1);
    @(posedge clk); #1;
    check("big_busy_after", 32'(b_busy), 0);
    check("big_err", 32'(b_err), 0);
    check("big_sh_valid", 32'(b_sh_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/automorph_ctrl.md
Name: automorph_ctrl

Overview:
- Sequencer for the Galois-automorphism shuffle datapath.
- Per job: latches a Galois element and a limb count, then streams each limb's N = 2^(INDEX_WIDTH-1) coefficients out of source BRAM in natural order.
- Drives the shuffle unit's valid/galois inputs aligned to BRAM read latency and tags shuffle writes with their limb.
- Inserts the inter-limb bubble the shuffle unit requires to reset its index accumulator; reports busy/done/error to the host.

Parameters:
INDEX_WIDTH, 13, Galois/index width; N = 2^(INDEX_WIDTH-1) coefficients per limb
LIMB_WIDTH, 4, limb counter width (max 2^LIMB_WIDTH-1 limbs per job)
RD_LAT, 2, source BRAM read latency in cycles (>=1)
GAP_CYCLES, 1, idle cycles between limbs (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  job request pulse; sampled only in IDLE
i_galois_elt  in  INDEX_WIDTH  Galois element; must be odd
i_num_limbs  in  LIMB_WIDTH  limbs in job; must be nonzero
o_busy  out  1  high from accepted start until done pulse inclusive
o_done  out  1  one-cycle job-complete pulse
o_err  out  1  one-cycle pulse on rejected start
o_rd_en  out  1  source BRAM read enable
o_rd_addr  out  INDEX_WIDTH-1  source coefficient address
o_rd_limb  out  LIMB_WIDTH  limb being read (BRAM bank/base select)
o_sh_valid  out  1  shuffle unit i_valid; o_rd_en delayed RD_LAT
o_galois_elt  out  INDEX_WIDTH  latched Galois element to shuffle unit
o_wr_limb  out  LIMB_WIDTH  limb of shuffle write in flight; aligned to shuffle o_we

Behaviour:
- Reset: FSM=IDLE; all outputs, counters, and delay-line contents 0. Reset mid-job aborts immediately. o_sh_valid is low from reset onward, so the shuffle accumulator clears; no done pulse.
- FSM states: IDLE, READ, GAP, DRAIN.
- IDLE:
  - i_start with odd i_galois_elt and i_num_limbs != 0: latch both, addr=0, limb=0, go to READ. o_busy rises next cycle.
  - i_start with even galois or zero limbs: o_err=1 next cycle for one cycle; stay IDLE; latched values unchanged.
- READ:
  - o_rd_en=1; o_rd_addr increments by 1 each cycle from 0.
  - At addr == N-1 with limb == num_limbs-1: go to DRAIN.
  - At addr == N-1 otherwise: go to GAP; addr wraps to 0, limb += 1.
- GAP: o_rd_en=0 for exactly GAP_CYCLES cycles, then READ. This guarantees o_sh_valid drops at least 1 cycle between limbs.
- DRAIN: o_rd_en=0; wait RD_LAT+1 cycles. o_done=1 in the last DRAIN cycle, then IDLE. o_busy falls the cycle after o_done.
- Timing, last read in cycle T:
  - last o_sh_valid at T+RD_LAT
  - last shuffle write at T+RD_LAT+1
  - o_done at T+RD_LAT+2
- o_sh_valid is o_rd_en through an RD_LAT-stage delay line.
- o_wr_limb is o_rd_limb through an (RD_LAT+1)-stage delay line.
- o_galois_elt holds constant while busy; it updates only on an accepted start.
- i_start while busy is ignored: no error, no effect.
- Throughput: II=1 within a limb. Job length is num_limbs*N + (num_limbs-1)*GAP_CYCLES + RD_LAT + 2 cycles from first o_rd_en to o_done.
- All counters are unsigned. The addr counter width is INDEX_WIDTH-1 and wraps naturally at N.

Decomposition:
- Shared package automorph_pkg holds: FSM state enum (2-bit), localparam N_COEFF = 2^(INDEX_WIDTH-1), and the DRAIN_CYCLES = RD_LAT+1 constant.
- One sub-module, valid_delay_line: parameterized WIDTH/DEPTH shift register with async reset to 0.
  - Instantiated twice: 1-bit valid at depth RD_LAT; LIMB_WIDTH tag at depth RD_LAT+1.

Test Plan:
- INDEX_WIDTH=4 (N=8), RD_LAT=2; start galois=3, limbs=1 -> o_rd_addr 0..7 on 8 consecutive cycles; o_sh_valid high 8 cycles starting 2 after first o_rd_en; o_done 4 cycles after last o_rd_en; o_busy deasserts the next cycle.
- N=8, limbs=3, galois=5, GAP_CYCLES=1 -> three 8-cycle read bursts with one idle cycle between each; o_rd_limb 0,1,2; o_wr_limb 0,1,2 aligned with o_sh_valid+1; total 8*3+2+4 = 30 cycles to o_done.
- Start galois=4, limbs=2 -> o_err one-cycle pulse, o_busy stays 0, no reads; start limbs=0 with galois=3 -> same.
- Second i_start (galois=7) during READ of a galois=3 job -> ignored; o_galois_elt remains 3 throughout; single o_done.
- rst_n low at addr=5 of limb 1 -> all outputs 0 asynchronously; after release, new job galois=9 limbs=1 starts at addr 0, limb 0, correct done timing.
- Default params (N=4096), limbs=2 -> o_done exactly 4096*2+1+4 = 8197 cycles after first o_rd_en.
